// File: rtl/full_adder_pkg.sv
// Shared types and constants for the bit-serial full-adder sequencer.
package full_adder_pkg;

    // Controller states: waiting for a request, shifting bits, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Supported operand widths.
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // True when a WIDTH value lies inside the supported range.
    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/full_adder_simple.sv
// One-bit full-adder cell. Sum and carry are purely combinational; clock and
// reset belong to the cell's standard port set but no state lives in here.
module full_adder_simple (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic unused_port_bits;

    assign unused_port_bits = clk_i & reset_n_i;

    // Classic sum/majority equations for one bit position.
    always_comb begin
        sum_o  = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end

endmodule

// File: rtl/full_adder_serial_ctrl.sv
// Bit-serial add/subtract sequencer: accepts an operand pair, pushes one bit
// per clock through a single full-adder slice (LSB first, registered carry)
// and presents the WIDTH-bit result plus carry-out on a response channel.
module full_adder_serial_ctrl
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             slice_sum;
    logic             slice_cout;

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("full_adder_serial_ctrl: WIDTH out of supported range");
        end
    endgenerate

    full_adder_simple u_slice (
        .clk_i     (clk_i),
        .reset_n_i (~reset_i),
        .a_i       (a_sh[0]),
        .b_i       (b_sh[0]),
        .cin_i     (carry),
        .sum_o     (slice_sum),
        .cout_o    (slice_cout)
    );

    // Next-state and handshake decode; ready/valid come from the state alone.
    always_comb begin
        next_state  = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
        busy_o      = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (bit_cnt == LAST_BIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State plus datapath: subtraction is A + ~B + 1, so B is inverted at load.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= a_i;
                        b_sh    <= sub_i ? ~b_i : b_i;
                        carry   <= sub_i ? 1'b1 : cin_i;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    sum_sh  <= {slice_sum, sum_sh[WIDTH-1:1]};
                    carry   <= slice_cout;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        sum_o  <= {slice_sum, sum_sh[WIDTH-1:1]};
                        cout_o <= slice_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_full_adder_serial_ctrl.sv
// Testbench for full_adder_serial_ctrl: an 8-bit instance for directed,
// reset, backpressure and random traffic, and a 2-bit instance swept over
// every operand combination. Expected results come from plain arithmetic.
module tb_full_adder_serial_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         acc;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       req_valid8, req_ready8, cin8, sub8, rsp_valid8, rsp_ready8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       req_valid2, req_ready2, cin2, sub2, rsp_valid2, rsp_ready2, cout2, busy2;
    logic [1:0] a2, b2, sum2;

    exp_t sb8[$];
    exp_t sb2[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rdy_auto8 = 1'b1;

    full_adder_serial_ctrl #(.WIDTH(8)) dut8 (
        .clk_i       (clk),
        .reset_i     (rst),
        .req_valid_i (req_valid8),
        .req_ready_o (req_ready8),
        .a_i         (a8),
        .b_i         (b8),
        .cin_i       (cin8),
        .sub_i       (sub8),
        .rsp_valid_o (rsp_valid8),
        .rsp_ready_i (rsp_ready8),
        .sum_o       (sum8),
        .cout_o      (cout8),
        .busy_o      (busy8)
    );

    full_adder_serial_ctrl #(.WIDTH(2)) dut2 (
        .clk_i       (clk),
        .reset_i     (rst),
        .req_valid_i (req_valid2),
        .req_ready_o (req_ready2),
        .a_i         (a2),
        .b_i         (b2),
        .cin_i       (cin2),
        .sub_i       (sub2),
        .rsp_valid_o (rsp_valid2),
        .rsp_ready_i (rsp_ready2),
        .sum_o       (sum2),
        .cout_o      (cout2),
        .busy_o      (busy2)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so response latency can be measured.
    always @(posedge clk) cyc <= cyc + 1;

    // Modulo-2^w arithmetic; in subtract mode the carry means "no borrow".
    function automatic exp_t refModel(input int w, input int a, input int b,
                                      input bit cin, input bit sub);
        exp_t r;
        int   m;
        int   t;
        m = 1 << w;
        if (sub) begin
            r.sum  = 8'((a - b + m) % m);
            r.cout = (a >= b);
        end else begin
            t      = a + b + int'(cin);
            r.sum  = 8'(t % m);
            r.cout = (t >= m);
        end
        r.acc = 0;
        return r;
    endfunction

    // Single comparison point: counts every check and reports any miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Wait for the chosen instance to be ready, issue one request, record its result.
    task automatic applyStimulus(input bit which, input logic [7:0] a, input logic [7:0] b,
                                 input bit cin, input bit sub);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!(which ? req_ready2 : req_ready8) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            total++;
            bad++;
            $display("[TB] FAIL req_ready_timeout: got 0, expected 1");
            return;
        end
        if (which) begin
            a2 = a[1:0]; b2 = b[1:0]; cin2 = cin; sub2 = sub; req_valid2 = 1'b1;
            e = refModel(2, int'(a[1:0]), int'(b[1:0]), cin, sub);
            e.acc = cyc + 1;
            sb2.push_back(e);
        end else begin
            a8 = a; b8 = b; cin8 = cin; sub8 = sub; req_valid8 = 1'b1;
            e = refModel(8, int'(a), int'(b), cin, sub);
            e.acc = cyc + 1;
            sb8.push_back(e);
        end
        @(negedge clk);
        if (which) begin
            req_valid2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
            cin2 = 1'($urandom); sub2 = 1'($urandom);
        end else begin
            req_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom); sub8 = 1'($urandom);
        end
    endtask

    // Wait until every issued request on an instance has been answered.
    task automatic waitDrain(input bit which);
        int guard;
        guard = 0;
        while (((which ? sb2.size() : sb8.size()) != 0 ||
                (which ? rsp_valid2 : rsp_valid8)) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            checkOutput("drain_timeout", which ? sb2.size() : sb8.size(), 0);
        end
    endtask

    // Random response backpressure for both instances.
    initial begin
        rsp_ready8 = 1'b0;
        rsp_ready2 = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy_auto8) rsp_ready8 = 1'($urandom_range(0, 1));
            rsp_ready2 = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the expected result when a response appears and checks it
    // every cycle it is presented, along with the acceptance-to-valid latency.
    initial begin : monitor
        bit         prev_v [2];
        bit         have   [2];
        exp_t       cur    [2];
        logic       v;
        logic [7:0] s;
        logic       c;
        for (int d = 0; d < 2; d++) begin
            prev_v[d] = 1'b0;
            have[d]   = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                v = (d == 1) ? rsp_valid2 : rsp_valid8;
                s = (d == 1) ? {6'b0, sum2} : sum8;
                c = (d == 1) ? cout2 : cout8;
                if (v && !prev_v[d]) begin
                    if (((d == 1) ? sb2.size() : sb8.size()) == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_rsp: dut%0d got rsp_valid=1, expected no response",
                                 (d == 1) ? 2 : 8);
                    end else begin
                        cur[d]  = (d == 1) ? sb2.pop_front() : sb8.pop_front();
                        have[d] = 1'b1;
                        checkOutput((d == 1) ? "latency2" : "latency8",
                                    cyc - cur[d].acc, (d == 1) ? 2 : 8);
                    end
                end
                if (v && have[d]) begin
                    checkOutput((d == 1) ? "sum2" : "sum8", {24'b0, s}, {24'b0, cur[d].sum});
                    checkOutput((d == 1) ? "cout2" : "cout8", c, cur[d].cout);
                end
                if (!v) have[d] = 1'b0;
                prev_v[d] = v;
            end
        end
    end

    // Main stimulus sequence.
    initial begin : stimulus
        exp_t bp;
        int   guard;
        bit   seen;
        rst = 1'b1;
        req_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        req_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready8", req_ready8, 1);
        checkOutput("rst_rsp_valid8", rsp_valid8, 0);
        checkOutput("rst_busy8", busy8, 0);
        checkOutput("rst_sum8", sum8, 0);
        checkOutput("rst_cout8", cout8, 0);
        checkOutput("rst_req_ready2", req_ready2, 1);
        checkOutput("rst_busy2", busy2, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset after bit 3 of an operation: it must vanish without a response.
        applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("midrun_busy", busy8, 1);
        rst = 1'b1;
        sb8.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_busy", busy8, 0);
        checkOutput("post_rst_req_ready", req_ready8, 1);
        checkOutput("post_rst_rsp_valid", rsp_valid8, 0);
        checkOutput("post_rst_sum", sum8, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid8) seen = 1'b1;
        end
        checkOutput("post_rst_no_rsp", seen, 0);
        applyStimulus(1'b0, 8'h03, 8'h04, 1'b0, 1'b0);

        // Directed add, wrap-around and subtract cases.
        applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h20, 8'h10, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h10, 8'h20, 1'b1, 1'b1);
        waitDrain(1'b0);

        // Backpressure: hold the response while new requests are waved at the DUT.
        rdy_auto8  = 1'b0;
        rsp_ready8 = 1'b0;
        bp = refModel(8, 'hC3, 'h5E, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hC3, 8'h5E, 1'b1, 1'b0);
        guard = 0;
        while (!rsp_valid8 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bp_valid_reached", rsp_valid8, 1);
        repeat (5) begin
            req_valid8 = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom);
            cin8 = 1'($urandom); sub8 = 1'($urandom);
            @(negedge clk);
            checkOutput("bp_req_ready", req_ready8, 0);
            checkOutput("bp_rsp_valid", rsp_valid8, 1);
            checkOutput("bp_sum", sum8, bp.sum);
            checkOutput("bp_cout", cout8, bp.cout);
        end
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; req_valid8 = 1'b1;
        rsp_ready8 = 1'b1;
        bp = refModel(8, 'h11, 'h22, 1'b0, 1'b0);
        bp.acc = cyc + 2;
        sb8.push_back(bp);
        @(negedge clk);
        rsp_ready8 = 1'b0;
        checkOutput("hs_req_ready", req_ready8, 1);
        checkOutput("hs_rsp_valid", rsp_valid8, 0);
        @(negedge clk);
        checkOutput("next_accept_busy", busy8, 1);
        checkOutput("next_accept_req_ready", req_ready8, 0);
        req_valid8 = 1'b0;
        rdy_auto8  = 1'b1;
        waitDrain(1'b0);

        // Random traffic on the 8-bit instance.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        waitDrain(1'b0);

        // Every (sub, a, b, cin) combination on the 2-bit instance.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    for (int c = 0; c < 2; c++) begin
                        applyStimulus(1'b1, 8'(a), 8'(b), 1'(c), 1'(s));
                    end
                end
            end
        end
        waitDrain(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_adder_serial_ctrl.md
# full_adder_serial_ctrl

Bit-serial add/subtract sequencer built around a single 1-bit full-adder slice. It accepts a WIDTH-bit operand pair over a valid/ready request channel and processes one bit per clock, LSB first, with a registered carry. It returns the WIDTH-bit result plus carry-out over a valid/ready response channel. It sits between a requesting datapath and the existing full-adder cell, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk_i  in  1  clock; all state changes on rising edge
- reset_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready; high only in IDLE
- a_i  in  WIDTH  operand A, sampled on request handshake only
- b_i  in  WIDTH  operand B, sampled on request handshake only
- cin_i  in  1  carry-in for add; ignored when sub_i=1
- sub_i  in  1  0 = A+B+cin_i, 1 = A−B (two's complement)
- rsp_valid_o  out  1  result valid; high only in DONE
- rsp_ready_i  in  1  result consumer ready
- sum_o  out  WIDTH  result register
- cout_o  out  1  final carry; in subtract mode 1 = no borrow (A ≥ B unsigned)
- busy_o  out  1  high when state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o, load a_sh=a_i and b_sh=(sub_i ? ~b_i : b_i).
  - Load carry=(sub_i ? 1 : cin_i) and bit_cnt=0, then go to RUN.
- RUN, each cycle:
  - Slice inputs are a_sh[0], b_sh[0] and carry.
  - sum_sh shifts right, taking the slice sum bit into its MSB; carry←slice cout.
  - a_sh and b_sh shift right; bit_cnt increments.
  - When bit_cnt==WIDTH−1, also load sum_o←final shifted sum, cout_o←final carry, then go to DONE.
- DONE:
  - rsp_valid_o=1.
  - On rsp_ready_i, go to IDLE.
  - sum_o and cout_o hold until the next RUN→DONE transition.
- req_valid_i is ignored outside IDLE. Operand changes after acceptance have no effect.
- bit_cnt width is $clog2(WIDTH). Arithmetic is modulo 2^WIDTH, and the carry out of bit WIDTH−1 goes to cout_o.
- Reset values:
  - state=IDLE.
  - req_ready_o=1 (combinational from IDLE).
  - rsp_valid_o=0, busy_o=0, sum_o=0, cout_o=0.
  - All shift registers, carry and bit_cnt = 0.
- Reset asserted mid-RUN or in DONE: the in-flight operation is discarded and no response is produced.

## Timing
- Acceptance edge E: state becomes RUN.
- Edges E+1 … E+WIDTH process bits 0 … WIDTH−1.
- rsp_valid_o rises after edge E+WIDTH (latency = WIDTH cycles from acceptance).
- Response handshake at edge F: state returns to IDLE. The earliest next acceptance is edge F+1.
- Minimum issue interval is WIDTH+2 cycles.
- Backpressure: DONE holds indefinitely while rsp_ready_i=0; outputs stay stable and req_ready_o stays 0.
- No combinational path from any input to req_ready_o or rsp_valid_o; both decode from the state register only.

## Structure
- Shared package full_adder_pkg:
  - state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - WIDTH legal-range constants, MIN_WIDTH=2 and MAX_WIDTH=32, with an elaboration-time check.
- One sub-module instance: full_adder_simple as the 1-bit slice.
  - clk_i connects to clk_i; its reset_n_i is tied to ~reset_i.
  - Its sum/cout are used combinationally within the cycle.
- Controller is a single always_ff for state/datapath registers plus a small always_comb for next-state and outputs.

## Test plan
- Reset: assert reset_i mid-RUN (after bit 3 of an op), release → rsp_valid_o never rises, busy_o=0, req_ready_o=1, sum_o=0. A following 0x03+0x04 returns 0x07.
- Add, WIDTH=8: a=0x5A, b=0x3C, cin=0, sub=0 → sum_o=0x96, cout_o=0, rsp_valid_o exactly 8 cycles after acceptance.
- Wrap-around: a=0xFF, b=0x01, cin=1 → sum_o=0x01, cout_o=1. Also a=0xFF, b=0x00, cin=1 → sum_o=0x00, cout_o=1.
- Subtract: 0x20−0x10 → sum_o=0x10, cout_o=1. 0x10−0x20 → sum_o=0xF0, cout_o=0. cin_i=1 is ignored in both cases.
- Backpressure: hold rsp_ready_i=0 for 5 cycles with req_valid_i=1 and changing operands → sum_o/cout_o stable, req_ready_o=0, no new acceptance. After the handshake, the next request is accepted exactly one cycle later.
- Exhaustive, WIDTH=2: all 2×4×4×2 (sub, a, b, cin) combinations checked against a reference model with random rsp_ready_i.
